// File: rtl/isram_responder.sv
// Instruction-side memory responder: fixed-latency fetch port over a 64-bit word array,
// with per-response PC and access-fault flag and a backdoor preload port.
module isram_responder #(
  parameter logic [63:0] BASE       = 64'h0000_0000_8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        isram_e,
  input  logic [63:0] isram_addr,
  input  logic        flush,
  input  logic        load_we,
  input  logic [63:0] load_addr,
  input  logic [63:0] load_wdata,
  output logic        inst_valid,
  output logic [63:0] inst_pc,
  output logic [31:0] inst,
  output logic        inst_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int IW    = DEPTH_LOG2;

  logic [63:0] r_mem [DEPTH];

  logic [63:0] r_vld_pc   [LATENCY];
  logic [31:0] r_vld_inst [LATENCY];
  logic        r_vld      [LATENCY];
  logic        r_err      [LATENCY];

  // Fetch decode. The explicit "< BASE" term keeps addresses below BASE
  // (including those near 2^64) from wrapping into the valid window.
  logic [63:0]   w_off;
  logic [IW-1:0] w_idx;
  logic          w_fault;
  logic          w_accept;
  logic [63:0]   w_word;
  logic [31:0]   w_rd_inst;

  assign w_off     = isram_addr - BASE;
  assign w_idx     = w_off[IW+2:3];
  assign w_fault   = (isram_addr < BASE) || (|w_off[63:IW+3]) || (|isram_addr[1:0]);
  assign w_accept  = isram_e && !rst && !flush;
  assign w_word    = r_mem[w_idx];
  assign w_rd_inst = w_off[2] ? w_word[63:32] : w_word[31:0];

  // Backdoor write decode; out-of-range writes are dropped.
  logic [63:0]   w_load_off;
  logic [IW-1:0] w_load_idx;
  logic          w_load_ok;

  assign w_load_off = load_addr - BASE;
  assign w_load_idx = w_load_off[IW+2:3];
  assign w_load_ok  = load_we && (load_addr >= BASE) && !(|w_load_off[63:IW+3]);

  logic w_unused_bits;
  assign w_unused_bits = ^{w_off[1:0], w_load_off[2:0]};

  // NOTE: the array has no reset so it maps onto RAM and keeps its image across rst;
  // preload writes are honoured even while rst is high.
  always_ff @(posedge clk) begin
    if (w_load_ok) begin
      r_mem[w_load_idx] <= load_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so the array read above sees
  // the pre-edge contents, which gives read-before-write on a same-word collision.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_vld[i]      <= 1'b0;
        r_vld_pc[i]   <= '0;
        r_vld_inst[i] <= '0;
        r_err[i]      <= 1'b0;
      end
    end else begin
      r_vld[0]      <= w_accept;
      r_vld_pc[0]   <= w_accept ? isram_addr : 64'd0;
      r_vld_inst[0] <= (w_accept && !w_fault) ? w_rd_inst : 32'd0;
      r_err[0]      <= w_accept && w_fault;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i]      <= r_vld[i-1];
        r_vld_pc[i]   <= r_vld_pc[i-1];
        r_vld_inst[i] <= r_vld_inst[i-1];
        r_err[i]      <= r_err[i-1];
      end
    end
  end

  assign inst_valid = r_vld[LATENCY-1];
  assign inst_pc    = r_vld_pc[LATENCY-1];
  assign inst       = r_vld_inst[LATENCY-1];
  assign inst_err   = r_err[LATENCY-1];

endmodule

// File: tb/tb_isram_responder.sv
// Directed bench for isram_responder: three instances (LATENCY 1, 2, 3) share one
// stimulus stream; expected values are hand-computed constants or a small image model.
module tb_isram_responder;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst;
  logic        isram_e;
  logic [63:0] isram_addr;
  logic        flush;
  logic        load_we;
  logic [63:0] load_addr;
  logic [63:0] load_wdata;

  logic        v1, v2, v3;
  logic [63:0] pc1, pc2, pc3;
  logic [31:0] in1, in2, in3;
  logic        er1, er2, er3;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] img [16];

  logic        hv  [100];
  logic [63:0] hpc [100];
  logic [31:0] hin [100];

  isram_responder #(.BASE(BASE), .DEPTH_LOG2(12), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .isram_e(isram_e), .isram_addr(isram_addr), .flush(flush),
    .load_we(load_we), .load_addr(load_addr), .load_wdata(load_wdata),
    .inst_valid(v1), .inst_pc(pc1), .inst(in1), .inst_err(er1));

  isram_responder #(.BASE(BASE), .DEPTH_LOG2(12), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .isram_e(isram_e), .isram_addr(isram_addr), .flush(flush),
    .load_we(load_we), .load_addr(load_addr), .load_wdata(load_wdata),
    .inst_valid(v2), .inst_pc(pc2), .inst(in2), .inst_err(er2));

  isram_responder #(.BASE(BASE), .DEPTH_LOG2(12), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .isram_e(isram_e), .isram_addr(isram_addr), .flush(flush),
    .load_we(load_we), .load_addr(load_addr), .load_wdata(load_wdata),
    .inst_valid(v3), .inst_pc(pc3), .inst(in3), .inst_err(er3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input string tag, input int lat, input logic v,
                             input logic [63:0] pc, input logic [31:0] ins, input logic err);
    logic        ov;
    logic [63:0] opc;
    logic [31:0] oin;
    logic        oer;
    case (lat)
      1:       begin ov = v1; opc = pc1; oin = in1; oer = er1; end
      2:       begin ov = v2; opc = pc2; oin = in2; oer = er2; end
      default: begin ov = v3; opc = pc3; oin = in3; oer = er3; end
    endcase
    check($sformatf("%s_l%0d_valid", tag, lat), {63'd0, ov}, {63'd0, v});
    check($sformatf("%s_l%0d_pc", tag, lat), opc, pc);
    check($sformatf("%s_l%0d_inst", tag, lat), {32'd0, oin}, {32'd0, ins});
    check($sformatf("%s_l%0d_err", tag, lat), {63'd0, oer}, {63'd0, err});
  endtask

  task automatic idle(input int n);
    isram_e = 1'b0;
    isram_addr = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [63:0] fault_addr [4];
    int k, h;
    logic e;

    fault_addr[0] = 64'h0000_0000_7FFF_FFFC;
    fault_addr[1] = 64'h0000_0000_8000_8000;
    fault_addr[2] = 64'h0000_0000_8000_0002;
    fault_addr[3] = 64'hFFFF_FFFF_FFFF_FFFC;

    img[0] = 64'h0010_0093_0000_0013;
    for (int i = 1; i < 16; i++) img[i] = {32'h5000_0000 | 32'(i), 32'h6000_0000 | 32'(i)};

    // Reset with preload overlapping it; a request during reset is dropped.
    rst = 1'b1; flush = 1'b0; load_we = 1'b0; load_addr = '0; load_wdata = '0;
    isram_e = 1'b1; isram_addr = BASE;
    for (int i = 0; i < 16; i++) begin
      load_we = 1'b1; load_addr = BASE + 64'(i) * 8; load_wdata = img[i];
      tick();
    end
    // Out-of-range write must not alias onto word 0.
    load_addr = BASE + 64'h8000; load_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    load_we = 1'b0;
    expect_resp("reset", 1, 1'b0, 64'd0, 32'd0, 1'b0);
    expect_resp("reset", 2, 1'b0, 64'd0, 32'd0, 1'b0);
    expect_resp("reset", 3, 1'b0, 64'd0, 32'd0, 1'b0);

    rst = 1'b0; isram_e = 1'b0;
    tick();
    expect_resp("rst_drop", 1, 1'b0, 64'd0, 32'd0, 1'b0);

    // Two consecutive fetches from word 0.
    isram_e = 1'b1; isram_addr = 64'h8000_0000;
    tick();
    expect_resp("fetch0", 1, 1'b1, 64'h8000_0000, 32'h0000_0013, 1'b0);
    isram_addr = 64'h8000_0004;
    tick();
    expect_resp("fetch4", 1, 1'b1, 64'h8000_0004, 32'h0010_0093, 1'b0);
    isram_e = 1'b0;
    tick();
    expect_resp("idle", 1, 1'b0, 64'd0, 32'd0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      isram_e = 1'b1; isram_addr = fault_addr[i];
      tick();
      expect_resp($sformatf("fault%0d", i), 1, 1'b1, fault_addr[i], 32'd0, 1'b1);
    end
    idle(4);

    // Flush at the third request kills everything in flight in the LATENCY=3 pipe.
    isram_e = 1'b1; isram_addr = 64'h8000_0000;
    tick();
    isram_addr = 64'h8000_0004;
    tick();
    isram_addr = 64'h8000_0008; flush = 1'b1;
    tick();
    expect_resp("flush_c3", 3, 1'b0, 64'd0, 32'd0, 1'b0);
    flush = 1'b0; isram_addr = 64'h8000_0000;
    tick();
    expect_resp("flush_c4", 3, 1'b0, 64'd0, 32'd0, 1'b0);
    isram_e = 1'b0; isram_addr = '0;
    tick();
    expect_resp("flush_c5", 3, 1'b0, 64'd0, 32'd0, 1'b0);
    tick();
    expect_resp("flush_c6", 3, 1'b1, 64'h8000_0000, 32'h0000_0013, 1'b0);
    tick();
    expect_resp("flush_c7", 3, 1'b0, 64'd0, 32'd0, 1'b0);
    idle(3);

    // Same-edge write and fetch of word 1 returns the old contents.
    load_we = 1'b1; load_addr = 64'h8000_0008; load_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
    isram_e = 1'b1; isram_addr = 64'h8000_0008;
    tick();
    load_we = 1'b0;
    expect_resp("rbw_old", 1, 1'b1, 64'h8000_0008, 32'h6000_0001, 1'b0);
    tick();
    expect_resp("rbw_new", 1, 1'b1, 64'h8000_0008, 32'hCCCC_DDDD, 1'b0);
    isram_addr = 64'h8000_000C;
    tick();
    expect_resp("rbw_hi", 1, 1'b1, 64'h8000_000C, 32'hAAAA_BBBB, 1'b0);
    img[1] = 64'hAAAA_BBBB_CCCC_DDDD;
    idle(4);

    // Reset with requests in flight in the LATENCY=2 pipe.
    isram_e = 1'b1; isram_addr = 64'h8000_0000;
    tick();
    isram_addr = 64'h8000_0004;
    tick();
    expect_resp("inflight", 2, 1'b1, 64'h8000_0000, 32'h0000_0013, 1'b0);
    rst = 1'b1; isram_e = 1'b0; isram_addr = '0;
    tick();
    expect_resp("rst_kill1", 2, 1'b0, 64'd0, 32'd0, 1'b0);
    rst = 1'b0;
    tick();
    expect_resp("rst_kill2", 2, 1'b0, 64'd0, 32'd0, 1'b0);
    isram_e = 1'b1; isram_addr = 64'h8000_0008;
    tick();
    expect_resp("retain", 1, 1'b1, 64'h8000_0008, 32'hCCCC_DDDD, 1'b0);
    isram_e = 1'b0; isram_addr = '0;
    tick();
    expect_resp("retain", 2, 1'b1, 64'h8000_0008, 32'hCCCC_DDDD, 1'b0);
    idle(4);

    // Random in-range stream; each instance must replay the history shifted by its latency.
    for (int n = 0; n < 100; n++) begin
      e = 1'($urandom_range(0, 1));
      k = int'($urandom_range(0, 15));
      h = int'($urandom_range(0, 1));
      isram_e = e;
      isram_addr = BASE + 64'(k) * 8 + 64'(h) * 4;
      hv[n]  = e;
      hpc[n] = e ? isram_addr : 64'd0;
      hin[n] = !e ? 32'd0 : (h == 1) ? img[k][63:32] : img[k][31:0];
      tick();
      for (int l = 1; l <= 3; l++) begin
        if (n >= l - 1) expect_resp("rand", l, hv[n-l+1], hpc[n-l+1], hin[n-l+1], 1'b0);
      end
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
